// File: rtl/crossbar_sched.sv
// crossbar_sched: per-output round-robin scheduler plus register stage that
// produces the one-hot select matrix and the captured input words feeding an
// N-port crossbar, with a valid/ready handshake on each output.
module crossbar_sched #(
  parameter  int DW = 16,
  parameter  int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_valid,
  input  logic [N*AW-1:0]   in_dest,
  input  logic [N*DW-1:0]   in_data,
  output logic [N-1:0]      in_ready,
  output logic [N*N-1:0]    sel,
  output logic [N*DW-1:0]   din,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready
);

  // w_req[o][j]: input j wants output o
  logic [N-1:0]  w_req      [N];
  logic [N-1:0]  w_gnt      [N];
  logic [N-1:0]  w_gnt_any;
  logic [AW-1:0] w_gnt_idx  [N];
  logic [AW-1:0] w_ptr_next [N];
  logic [N-1:0]  w_free;
  logic [N-1:0]  w_ready;
  logic [N-1:0]  w_xfer;

  logic [AW-1:0] r_ptr      [N];
  logic [N-1:0]  r_out_valid;
  logic [N*N-1:0] r_sel;
  logic [N*DW-1:0] r_din;

  // Decode each input's destination into a per-output request vector.
  // A destination index >= N matches no output and therefore never requests.
  always_comb begin
    for (int o = 0; o < N; o++) begin
      w_req[o] = '0;
      for (int j = 0; j < N; j++) begin
        w_req[o][j] = in_valid[j] && (in_dest[j*AW +: AW] == AW'(o));
      end
    end
  end

  // A slot can take a new word when empty or being drained this cycle.
  always_comb begin
    for (int o = 0; o < N; o++) begin
      w_free[o] = !r_out_valid[o] || out_ready[o];
    end
  end

  // Round-robin pick per output, scanning upward from the pointer with wrap.
  // Grants are suppressed during reset so nothing is accepted.
  always_comb begin : arb_comb
    int   idx;
    logic found;
    for (int o = 0; o < N; o++) begin
      w_gnt[o]     = '0;
      w_gnt_any[o] = 1'b0;
      w_gnt_idx[o] = '0;
      found        = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = int'(r_ptr[o]) + k;
        if (idx >= N) idx = idx - N;
        if (!found && !rst && w_free[o] && w_req[o][idx]) begin
          found         = 1'b1;
          w_gnt[o][idx] = 1'b1;
          w_gnt_any[o]  = 1'b1;
          w_gnt_idx[o]  = AW'(idx);
        end
      end
    end
  end

  // Pointer moves to the input just after the winner, wrapping at N.
  always_comb begin
    for (int o = 0; o < N; o++) begin
      if (w_gnt_idx[o] == AW'(N-1)) w_ptr_next[o] = '0;
      else                          w_ptr_next[o] = w_gnt_idx[o] + AW'(1);
    end
  end

  // An input has a single destination, so at most one row can grant it.
  always_comb begin
    w_ready = '0;
    for (int o = 0; o < N; o++) begin
      w_ready = w_ready | w_gnt[o];
    end
    w_xfer = w_ready & in_valid;
  end

  // Per-output slot state: load on grant, clear when drained, hold when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
      r_sel       <= '0;
      for (int o = 0; o < N; o++) r_ptr[o] <= '0;
    end else begin
      for (int o = 0; o < N; o++) begin
        if (w_free[o]) begin
          r_sel[o*N +: N] <= w_gnt[o];
          r_out_valid[o]  <= w_gnt_any[o];
          if (w_gnt_any[o]) r_ptr[o] <= w_ptr_next[o];
        end
      end
    end
  end

  // Capture each input's word only when it actually transfers; a held slot
  // blocks its source, so the word a stalled output points at stays intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_din <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (w_xfer[j]) r_din[j*DW +: DW] <= in_data[j*DW +: DW];
      end
    end
  end

  assign in_ready  = w_ready;
  assign sel       = r_sel;
  assign din       = r_din;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_crossbar_sched.sv
// Directed testbench for crossbar_sched: an 8-port instance for the main
// scenarios and a 6-port instance for out-of-range destinations.
module tb_crossbar_sched;

  logic clk;
  logic rst;

  logic [7:0]   in_valid;
  logic [23:0]  in_dest;
  logic [127:0] in_data;
  logic [7:0]   in_ready;
  logic [63:0]  sel;
  logic [127:0] din;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;

  logic [5:0]   in_valid6;
  logic [17:0]  in_dest6;
  logic [95:0]  in_data6;
  logic [5:0]   in_ready6;
  logic [35:0]  sel6;
  logic [95:0]  din6;
  logic [5:0]   out_valid6;
  logic [5:0]   out_ready6;

  int vectors;
  int errors;

  crossbar_sched #(.DW(16), .N(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data),
    .in_ready(in_ready), .sel(sel), .din(din),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  crossbar_sched #(.DW(16), .N(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_dest(in_dest6), .in_data(in_data6),
    .in_ready(in_ready6), .sel(sel6), .din(din6),
    .out_valid(out_valid6), .out_ready(out_ready6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int j, input logic v, input logic [2:0] d, input logic [15:0] w);
    in_valid[j]        = v;
    in_dest[j*3 +: 3]  = d;
    in_data[j*16 +: 16] = w;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 8'hFF;
    in_dest = '0;
    in_data = '0;
    out_ready = 8'hFF;
    in_valid6 = 6'h3F;
    in_dest6 = '0;
    in_data6 = '0;
    out_ready6 = 6'h3F;
    step();
    step();
    vectors++;
    if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready: got %h want %h", in_ready, 8'h00); end
    vectors++;
    if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_out_valid: got %h want %h", out_valid, 8'h00); end
    vectors++;
    if (sel !== 64'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", sel); end
    vectors++;
    if (din !== 128'h0) begin errors++; $display("FAIL reset_din: got %h want 0", din); end
    vectors++;
    if (in_ready6 !== 6'h00 || out_valid6 !== 6'h00 || sel6 !== 36'h0) begin
      errors++; $display("FAIL reset_n6: in_ready %h out_valid %h sel %h want all 0", in_ready6, out_valid6, sel6);
    end
    in_valid = '0;
    in_valid6 = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_permutation();
    logic [63:0] exp_sel;
    exp_sel = '0;
    for (int j = 0; j < 8; j++) set_in(j, 1'b1, 3'(7 - j), 16'h1000 + 16'(j));
    out_ready = 8'hFF;
    #1;
    vectors++;
    if (in_ready !== 8'hFF) begin errors++; $display("FAIL perm_in_ready: got %h want ff", in_ready); end
    step();
    in_valid = '0;
    for (int o = 0; o < 8; o++) exp_sel[o*8 + (7 - o)] = 1'b1;
    vectors++;
    if (out_valid !== 8'hFF) begin errors++; $display("FAIL perm_out_valid: got %h want ff", out_valid); end
    vectors++;
    if (sel !== exp_sel) begin errors++; $display("FAIL perm_sel: got %h want %h", sel, exp_sel); end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (din[j*16 +: 16] !== 16'h1000 + 16'(j)) begin
        errors++; $display("FAIL perm_din%0d: got %h want %h", j, din[j*16 +: 16], 16'h1000 + 16'(j));
      end
    end
    step();
    vectors++;
    if (out_valid !== 8'h00 || sel !== 64'h0) begin
      errors++; $display("FAIL perm_drain: out_valid %h sel %h want 0/0", out_valid, sel);
    end
  endtask

  task automatic test_contention();
    int order [6] = '{0, 3, 5, 0, 3, 5};
    logic [15:0] word [8];
    logic [15:0] sent;
    int g;
    out_ready = 8'hFF;
    for (int j = 0; j < 8; j++) word[j] = 16'hA000 + 16'(j << 4);
    set_in(0, 1'b1, 3'd2, word[0]);
    set_in(3, 1'b1, 3'd2, word[3]);
    set_in(5, 1'b1, 3'd2, word[5]);
    #1;
    for (int c = 0; c < 6; c++) begin
      g = order[c];
      vectors++;
      if (in_ready !== 8'(1 << g)) begin
        errors++; $display("FAIL cont_ready_c%0d: got %h want %h", c, in_ready, 8'(1 << g));
      end
      sent = word[g];
      step();
      vectors++;
      if (sel[2*8 +: 8] !== 8'(1 << g)) begin
        errors++; $display("FAIL cont_sel_c%0d: got %h want %h", c, sel[2*8 +: 8], 8'(1 << g));
      end
      vectors++;
      if (out_valid !== 8'h04) begin errors++; $display("FAIL cont_valid_c%0d: got %h want 04", c, out_valid); end
      vectors++;
      if (din[g*16 +: 16] !== sent) begin
        errors++; $display("FAIL cont_din_c%0d: got %h want %h", c, din[g*16 +: 16], sent);
      end
      word[g] = sent + 16'd1;
      in_data[g*16 +: 16] = word[g];
      #1;
    end
    in_valid = '0;
    step();
    vectors++;
    if (out_valid !== 8'h00) begin errors++; $display("FAIL cont_drain: got %h want 00", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 8'hEF;
    set_in(6, 1'b1, 3'd4, 16'hB006);
    #1;
    vectors++;
    if (in_ready !== 8'h40) begin errors++; $display("FAIL bp_load_ready: got %h want 40", in_ready); end
    step();
    in_valid[6] = 1'b0;
    set_in(1, 1'b1, 3'd4, 16'hB001);
    #1;
    vectors++;
    if (out_valid !== 8'h10 || sel[4*8 +: 8] !== 8'h40) begin
      errors++; $display("FAIL bp_loaded: out_valid %h sel4 %h want 10/40", out_valid, sel[4*8 +: 8]);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_hold_ready_c%0d: got %h want 00", c, in_ready); end
      step();
      vectors++;
      if (out_valid !== 8'h10 || sel[4*8 +: 8] !== 8'h40 || din[6*16 +: 16] !== 16'hB006 || din[1*16 +: 16] !== 16'h1001) begin
        errors++;
        $display("FAIL bp_hold_c%0d: out_valid %h sel4 %h din6 %h din1 %h want 10/40/b006/1001",
                 c, out_valid, sel[4*8 +: 8], din[6*16 +: 16], din[1*16 +: 16]);
      end
    end
    out_ready = 8'hFF;
    #1;
    vectors++;
    if (in_ready !== 8'h02) begin errors++; $display("FAIL bp_release_ready: got %h want 02", in_ready); end
    step();
    in_valid[1] = 1'b0;
    vectors++;
    if (out_valid !== 8'h10 || sel[4*8 +: 8] !== 8'h02 || din[1*16 +: 16] !== 16'hB001) begin
      errors++;
      $display("FAIL bp_reload: out_valid %h sel4 %h din1 %h want 10/02/b001", out_valid, sel[4*8 +: 8], din[1*16 +: 16]);
    end
    step();
    vectors++;
    if (out_valid !== 8'h00) begin errors++; $display("FAIL bp_drain: got %h want 00", out_valid); end
  endtask

  task automatic test_bad_dest();
    logic [35:0] exp_sel6;
    out_ready6 = 6'h3F;
    in_valid6[2] = 1'b1;
    in_dest6[2*3 +: 3] = 3'd7;
    in_data6[2*16 +: 16] = 16'hC002;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (in_ready6 !== 6'h00) begin errors++; $display("FAIL bad7_ready_c%0d: got %h want 00", c, in_ready6); end
      step();
      vectors++;
      if (out_valid6 !== 6'h00 || sel6 !== 36'h0 || din6 !== 96'h0) begin
        errors++; $display("FAIL bad7_state_c%0d: out_valid %h sel %h din %h want 0", c, out_valid6, sel6, din6);
      end
    end
    in_valid6 = '0;
    step();
    in_valid6[2] = 1'b1;
    in_dest6[2*3 +: 3] = 3'd6;
    #1;
    vectors++;
    if (in_ready6 !== 6'h00) begin errors++; $display("FAIL bad6_ready: got %h want 00", in_ready6); end
    step();
    vectors++;
    if (out_valid6 !== 6'h00 || sel6 !== 36'h0) begin
      errors++; $display("FAIL bad6_state: out_valid %h sel %h want 0", out_valid6, sel6);
    end
    in_valid6 = '0;
    step();
    in_valid6[2] = 1'b1;
    in_dest6[2*3 +: 3] = 3'd5;
    #1;
    vectors++;
    if (in_ready6 !== 6'h04) begin errors++; $display("FAIL good5_ready: got %h want 04", in_ready6); end
    step();
    in_valid6 = '0;
    exp_sel6 = '0;
    exp_sel6[5*6 + 2] = 1'b1;
    vectors++;
    if (out_valid6 !== 6'h20 || sel6 !== exp_sel6 || din6[2*16 +: 16] !== 16'hC002) begin
      errors++;
      $display("FAIL good5_state: out_valid %h sel %h din2 %h want 20/%h/c002", out_valid6, sel6, din6[2*16 +: 16], exp_sel6);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 8'h00;
    set_in(2, 1'b1, 3'd0, 16'hD002);
    set_in(4, 1'b1, 3'd1, 16'hD004);
    set_in(6, 1'b1, 3'd3, 16'hD006);
    #1;
    vectors++;
    if (in_ready !== 8'h54) begin errors++; $display("FAIL rm_load_ready: got %h want 54", in_ready); end
    step();
    in_valid = '0;
    step();
    vectors++;
    if (out_valid !== 8'h0B) begin errors++; $display("FAIL rm_stalled: got %h want 0b", out_valid); end
    set_in(3, 1'b1, 3'd1, 16'hE003);
    set_in(6, 1'b1, 3'd1, 16'hE006);
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h00) begin errors++; $display("FAIL rm_rst_ready: got %h want 00", in_ready); end
    step();
    vectors++;
    if (out_valid !== 8'h00 || sel !== 64'h0 || din !== 128'h0) begin
      errors++; $display("FAIL rm_cleared: out_valid %h sel %h din %h want 0", out_valid, sel, din);
    end
    rst = 1'b0;
    out_ready = 8'hFF;
    #1;
    vectors++;
    if (in_ready !== 8'h08) begin errors++; $display("FAIL rm_first_grant: got %h want 08", in_ready); end
    step();
    vectors++;
    if (sel[1*8 +: 8] !== 8'h08 || out_valid !== 8'h02 || din[3*16 +: 16] !== 16'hE003) begin
      errors++;
      $display("FAIL rm_first_load: sel1 %h out_valid %h din3 %h want 08/02/e003", sel[1*8 +: 8], out_valid, din[3*16 +: 16]);
    end
    vectors++;
    if (in_ready !== 8'h40) begin errors++; $display("FAIL rm_second_grant: got %h want 40", in_ready); end
    step();
    in_valid = '0;
    vectors++;
    if (sel[1*8 +: 8] !== 8'h40) begin errors++; $display("FAIL rm_second_load: got %h want 40", sel[1*8 +: 8]); end
    step();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    in_valid = '0; in_dest = '0; in_data = '0; out_ready = '0;
    in_valid6 = '0; in_dest6 = '0; in_data6 = '0; out_ready6 = '0;
    test_reset();
    test_permutation();
    test_contention();
    test_backpressure();
    test_bad_dest();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
